mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory port (AR/R read channels, AW/W write channels, no write response) between two requesters, e.g. two sort_circuit instances or a sort engine plus a host loader.
- Reads and writes are arbitrated independently.
- Each direction allows one outstanding transaction, granted round-robin and held until that transaction completes.
- Sits between the requesters' memory interfaces and the single memory model/controller.

Parameters:
- ADDR_WDTH, 4, address width of AR/AW channels.
- DATA_WDTH, 32, data width of R/W channels.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_ar_valid  in  2  per-requester read address valid; bit k is requester k.
- m_ar_ready  out  2  per-requester read address ready.
- m_ar_address  in  2*ADDR_WDTH  requester k at [k*ADDR_WDTH +: ADDR_WDTH].
- m_r_valid  out  2  per-requester read data valid.
- m_r_ready  in  2  per-requester read data ready.
- m_r_data  out  DATA_WDTH  read data, broadcast to both requesters.
- m_aw_valid  in  2  per-requester write address valid.
- m_aw_ready  out  2  per-requester write address ready.
- m_aw_address  in  2*ADDR_WDTH  packed like m_ar_address.
- m_w_valid  in  2  per-requester write data valid.
- m_w_ready  out  2  per-requester write data ready.
- m_w_data  in  2*DATA_WDTH  requester k at [k*DATA_WDTH +: DATA_WDTH].
- s_ar_valid, s_ar_address  out  1, ADDR_WDTH  memory-side read address.
- s_ar_ready  in  1  memory-side read address ready.
- s_r_valid, s_r_data  in  1, DATA_WDTH  memory-side read data.
- s_r_ready  out  1  memory-side read data ready.
- s_aw_valid, s_aw_address  out  1, ADDR_WDTH  memory-side write address.
- s_aw_ready  in  1  memory-side write address ready.
- s_w_valid, s_w_data  out  1, DATA_WDTH  memory-side write data.
- s_w_ready  in  1  memory-side write data ready.
- rd_busy, rd_owner  out  1, 1  read grant active / granted requester index.
- wr_busy, wr_owner  out  1, 1  write grant active / granted requester index.

Behaviour:
- Reset (async, rst=1):
  - read FSM to RD_IDLE, write FSM to WR_IDLE.
  - rd_last=1 and wr_last=1, so requester 0 wins first.
  - aw_done=w_done=0.
  - All valid/ready outputs 0; rd_busy=wr_busy=0; rd_owner=wr_owner=0.
  - Data/address outputs driven from the owner mux, so all zero while idle.
- Handshake: a transfer occurs on a cycle where valid & ready are both 1 at the rising edge. Non-owners always see ready=0 and r_valid=0.
- Read FSM:
  - RD_IDLE: if m_ar_valid!=0, pick the owner: the requester that is not rd_last if it requests, else the other. Register rd_owner and go to RD_ADDR. Latency: s_ar_valid rises exactly 1 cycle after the request is first sampled.
  - RD_ADDR: s_ar_valid=m_ar_valid[owner], s_ar_address=owner slice, m_ar_ready[owner]=s_ar_ready. On s_ar handshake go to RD_DATA. If the owner drops valid (protocol violation), stay in RD_ADDR; the grant is not revoked.
  - RD_DATA: m_r_valid[owner]=s_r_valid, s_r_ready=m_r_ready[owner]. On handshake: rd_last<=owner, go to RD_IDLE.
  - rd_busy=1 in RD_ADDR and RD_DATA. No new AR is forwarded while in RD_DATA.
- Write FSM:
  - WR_IDLE: same round-robin pick using wr_last and m_aw_valid|m_w_valid. Register wr_owner, clear aw_done/w_done, go to WR_BUSY.
  - WR_BUSY, AW channel: s_aw_valid=m_aw_valid[owner]&~aw_done, m_aw_ready[owner]=s_aw_ready&~aw_done.
  - WR_BUSY, W channel: s_w_valid=m_w_valid[owner]&~w_done, m_w_ready[owner]=s_w_ready&~w_done.
  - AW and W may handshake in either order or in the same cycle. Set the matching done flag on each handshake.
  - Exit to WR_IDLE with wr_last<=owner on the cycle both are done, counting handshakes in that same cycle.
  - Never forward a second AW or W within one grant.
- Read and write FSMs are fully independent: one requester may own reads while the other owns writes. Memory-side ordering is not enforced here.
- Simultaneous requests in idle: the non-last requester wins. The loser's valid stays asserted and is granted next, in the cycle right after the winner returns to idle.
- Single requester repeatedly requesting: it is granted back-to-back; rd_last does not block it.
- Reset mid-transaction: the grant is dropped immediately and nothing is completed to the requester. The memory side must also be reset.

Decomposition:
- Package mem_port_arbiter_pkg: read state encodings (RD_IDLE, RD_ADDR, RD_DATA), write state encodings (WR_IDLE, WR_BUSY), and a localparam NUM_REQ=2.
- Sub-module rr_arb2: 2-way round-robin picker. Inputs: req[1:0], last. Outputs: any, pick. Instantiated once for reads and once for writes.

Test Plan:
- Reset then idle: all outputs 0. m_ar_valid=01, addr 0x3 -> s_ar_valid=1 at cycle+1 with s_ar_address=0x3. s_r_data=0xDEADBEEF with ready -> m_r_valid=01, rd_busy falls the cycle after.
- Both m_ar_valid=11 at the same time, after reset -> requester 0 served first, then requester 1. Next contest has requester 0 win again only after requester 1 has been served (round-robin alternates).
- Write with W before AW: m_w_valid[1] handshakes at t, AW at t+3 -> exactly one s_w and one s_aw beat; wr_busy falls after t+3; m_w_ready[1]=0 during t+1..t+3.
- AW and W handshake in the same cycle for requester 0 -> grant released in that cycle; requester 1's pending write gets s_aw_valid 1 cycle later.
- Concurrent read by requester 0 and write by requester 1 -> both proceed in parallel; rd_owner=0, wr_owner=1; no cross-routing of ready/valid.
- Assert rst during RD_DATA with s_r_valid=0 -> all outputs 0 asynchronously; after release, a new request is granted to requester 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_BUSY = 1'b1
  } wr_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: favour the requester that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       pick
);
  always_comb begin
    any  = |req;
    pick = req[~last] ? ~last : last;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one AR/R + AW/W memory port between two requesters; reads and writes
// are granted independently, one outstanding transaction per direction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             m_ar_valid,
  output logic [NUM_REQ-1:0]             m_ar_ready,
  input  logic [NUM_REQ*ADDR_WDTH-1:0]   m_ar_address,
  output logic [NUM_REQ-1:0]             m_r_valid,
  input  logic [NUM_REQ-1:0]             m_r_ready,
  output logic [DATA_WDTH-1:0]           m_r_data,
  input  logic [NUM_REQ-1:0]             m_aw_valid,
  output logic [NUM_REQ-1:0]             m_aw_ready,
  input  logic [NUM_REQ*ADDR_WDTH-1:0]   m_aw_address,
  input  logic [NUM_REQ-1:0]             m_w_valid,
  output logic [NUM_REQ-1:0]             m_w_ready,
  input  logic [NUM_REQ*DATA_WDTH-1:0]   m_w_data,
  output logic                           s_ar_valid,
  output logic [ADDR_WDTH-1:0]           s_ar_address,
  input  logic                           s_ar_ready,
  input  logic                           s_r_valid,
  input  logic [DATA_WDTH-1:0]           s_r_data,
  output logic                           s_r_ready,
  output logic                           s_aw_valid,
  output logic [ADDR_WDTH-1:0]           s_aw_address,
  input  logic                           s_aw_ready,
  output logic                           s_w_valid,
  output logic [DATA_WDTH-1:0]           s_w_data,
  input  logic                           s_w_ready,
  output logic                           rd_busy,
  output logic                           rd_owner,
  output logic                           wr_busy,
  output logic                           wr_owner
);
  logic [NUM_REQ-1:0][ADDR_WDTH-1:0] ar_addr_v, aw_addr_v;
  logic [NUM_REQ-1:0][DATA_WDTH-1:0] w_data_v;
  assign ar_addr_v = m_ar_address;
  assign aw_addr_v = m_aw_address;
  assign w_data_v  = m_w_data;

  // ---------------- read side ----------------
  rd_state_e rd_state, rd_next;
  logic      rd_last, rd_any, rd_pick, ar_hs, r_hs;

  rr_arb2 u_rd_arb (.req(m_ar_valid), .last(rd_last), .any(rd_any), .pick(rd_pick));

  assign ar_hs = s_ar_valid & s_ar_ready;
  assign r_hs  = s_r_valid & s_r_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_owner <= 1'b0;
      rd_last  <= 1'b1;
    end else begin
      rd_state <= rd_next;
      if (rd_state == RD_IDLE && rd_any) rd_owner <= rd_pick;
      if (rd_state == RD_DATA && r_hs)   rd_last  <= rd_owner;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_any) rd_next = RD_ADDR;
      RD_ADDR: if (ar_hs)  rd_next = RD_DATA;
      RD_DATA: if (r_hs)   rd_next = RD_IDLE;
      default:             rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    s_ar_valid   = 1'b0;
    s_ar_address = '0;
    m_ar_ready   = '0;
    m_r_valid    = '0;
    m_r_data     = '0;
    s_r_ready    = 1'b0;
    rd_busy      = (rd_state != RD_IDLE);
    case (rd_state)
      RD_ADDR: begin
        s_ar_valid           = m_ar_valid[rd_owner];
        s_ar_address         = ar_addr_v[rd_owner];
        m_ar_ready[rd_owner] = s_ar_ready;
      end
      RD_DATA: begin
        m_r_valid[rd_owner] = s_r_valid;
        m_r_data            = s_r_data;
        s_r_ready           = m_r_ready[rd_owner];
      end
      default: ;
    endcase
  end

  // ---------------- write side ----------------
  wr_state_e wr_state, wr_next;
  logic      wr_last, wr_any, wr_pick, aw_done, w_done, aw_hs, w_hs, wr_fin;

  rr_arb2 u_wr_arb (.req(m_aw_valid | m_w_valid), .last(wr_last), .any(wr_any), .pick(wr_pick));

  assign aw_hs  = s_aw_valid & s_aw_ready;
  assign w_hs   = s_w_valid & s_w_ready;
  // A handshake landing in the same cycle counts toward completion.
  assign wr_fin = (aw_done | aw_hs) & (w_done | w_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      wr_owner <= 1'b0;
      wr_last  <= 1'b1;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (wr_state == WR_IDLE && wr_any) begin
        wr_owner <= wr_pick;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else if (wr_state == WR_BUSY) begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
        if (wr_fin) wr_last <= wr_owner;
      end
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_any) wr_next = WR_BUSY;
      WR_BUSY: if (wr_fin) wr_next = WR_IDLE;
      default:             wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    s_aw_valid   = 1'b0;
    s_aw_address = '0;
    m_aw_ready   = '0;
    s_w_valid    = 1'b0;
    s_w_data     = '0;
    m_w_ready    = '0;
    wr_busy      = (wr_state == WR_BUSY);
    if (wr_state == WR_BUSY) begin
      s_aw_valid           = m_aw_valid[wr_owner] & ~aw_done;
      s_aw_address         = aw_addr_v[wr_owner];
      m_aw_ready[wr_owner] = s_aw_ready & ~aw_done;
      s_w_valid            = m_w_valid[wr_owner] & ~w_done;
      s_w_data             = w_data_v[wr_owner];
      m_w_ready[wr_owner]  = s_w_ready & ~w_done;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of read transactions plus
// hand-written write, concurrency and reset sequences.
module tb_mem_port_arbiter;
  logic        clk = 0, rst = 1;
  logic [1:0]  m_ar_valid = 0, m_ar_ready, m_r_valid, m_r_ready = 0;
  logic [1:0]  m_aw_valid = 0, m_aw_ready, m_w_valid = 0, m_w_ready;
  logic [7:0]  m_ar_address = 0, m_aw_address = 0;
  logic [63:0] m_w_data = 0;
  logic [31:0] m_r_data, s_r_data = 0, s_w_data;
  logic        s_ar_valid, s_ar_ready = 0, s_r_valid = 0, s_r_ready;
  logic        s_aw_valid, s_aw_ready = 0, s_w_valid, s_w_ready = 0;
  logic [3:0]  s_ar_address, s_aw_address;
  logic        rd_busy, rd_owner, wr_busy, wr_owner;

  mem_port_arbiter #(.ADDR_WDTH(4), .DATA_WDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_address(m_ar_address),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_address(m_aw_address),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .s_ar_valid(s_ar_valid), .s_ar_address(s_ar_address), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_ready(s_r_ready),
    .s_aw_valid(s_aw_valid), .s_aw_address(s_aw_address), .s_aw_ready(s_aw_ready),
    .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_ready(s_w_ready),
    .rd_busy(rd_busy), .rd_owner(rd_owner), .wr_busy(wr_busy), .wr_owner(wr_owner)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int aw_beats = 0, w_beats = 0;
  logic [31:0] sbq[$];

  always @(posedge clk)
    if (!rst) begin
      aw_beats <= aw_beats + int'(s_aw_valid & s_aw_ready);
      w_beats  <= w_beats + int'(s_w_valid & s_w_ready);
    end

  typedef struct {
    int          id;
    logic [3:0]  addr;
    logic [31:0] data;
  } rd_vec_t;
  rd_vec_t tbl[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Read transaction for requester id; expected data is queued when the
  // memory side presents it and popped when the requester sees r_valid.
  task automatic rd_xact(input int id, input logic [3:0] a, input logic [31:0] d);
    logic [31:0] exp_d;
    m_ar_valid[id] = 1'b1;
    m_ar_address[id*4 +: 4] = a;
    settle();
    for (int n = 0; n < 20; n++) begin
      if (s_ar_valid && rd_owner == id[0]) break;
      cyc(); settle();
    end
    check("ar_grant", {s_ar_valid, rd_owner}, {1'b1, id[0]});
    check("ar_addr", s_ar_address, a);
    s_ar_ready = 1'b1; settle();
    check("ar_ready", m_ar_ready, 2'b01 << id);
    cyc();
    s_ar_ready = 1'b0; m_ar_valid[id] = 1'b0;
    s_r_valid = 1'b1; s_r_data = d; m_r_ready = 2'b11;
    sbq.push_back(d);
    settle();
    check("r_valid", m_r_valid, 2'b01 << id);
    check("s_ar_quiet", s_ar_valid, 0);
    if (m_r_valid[id]) begin
      exp_d = sbq.pop_front();
      check("r_data", m_r_data, exp_d);
    end else sbq.delete();
    cyc();
    s_r_valid = 1'b0; s_r_data = 0; m_r_ready = 2'b00; settle();
    check("rd_busy_fall", rd_busy, 0);
  endtask

  initial begin
    tbl[0] = '{0, 4'h3, 32'hDEADBEEF};
    tbl[1] = '{1, 4'hA, 32'h12345678};
    tbl[2] = '{1, 4'hF, 32'hCAFEF00D};
    tbl[3] = '{0, 4'h0, 32'h00000000};
    tbl[4] = '{0, 4'h7, 32'hFFFFFFFF};

    // Reset with busy inputs: everything must stay quiet.
    m_ar_valid = 2'b11; m_aw_valid = 2'b11; m_w_valid = 2'b11; m_r_ready = 2'b11;
    m_ar_address = 8'h5A; m_aw_address = 8'hC3; m_w_data = {32'h11111111, 32'h22222222};
    s_r_data = 32'hFFFF0000; s_r_valid = 1; s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1;
    #12;
    check("rst_ctrl", {m_ar_ready, m_r_valid, m_aw_ready, m_w_ready, s_ar_valid, s_r_ready,
                       s_aw_valid, s_w_valid, rd_busy, rd_owner, wr_busy, wr_owner}, 0);
    check("rst_data", {m_r_data, s_w_data}, 0);
    check("rst_addr", {s_ar_address, s_aw_address}, 0);
    m_ar_valid = 0; m_aw_valid = 0; m_w_valid = 0; m_r_ready = 0;
    m_ar_address = 0; m_aw_address = 0; m_w_data = 0;
    s_r_data = 0; s_r_valid = 0; s_ar_ready = 0; s_aw_ready = 0; s_w_ready = 0;
    cyc(); rst = 0;

    // Read contest right after reset: 0 first, then 1, then 0 wins again.
    cyc();
    m_ar_valid = 2'b11; m_ar_address = {4'h9, 4'h5}; settle();
    check("contest_lat0", s_ar_valid, 0);
    cyc(); settle();
    check("contest1_owner", {rd_busy, rd_owner}, 2'b10);
    rd_xact(0, 4'h5, 32'hA0A0A0A0);
    cyc(); settle();
    check("contest_rr_next", {s_ar_valid, rd_owner, s_ar_address}, {1'b1, 1'b1, 4'h9});
    rd_xact(1, 4'h9, 32'hB1B1B1B1);
    m_ar_valid = 2'b11; m_ar_address = {4'h2, 4'h1};
    cyc(); settle();
    check("contest2_owner", {rd_busy, rd_owner}, 2'b10);
    rd_xact(0, 4'h1, 32'h0C0C0C0C);
    rd_xact(1, 4'h2, 32'h1D1D1D1D);

    // Table of single-requester reads, including back-to-back same requester.
    foreach (tbl[i]) begin
      cyc();
      m_ar_valid[tbl[i].id] = 1'b1;
      m_ar_address[tbl[i].id*4 +: 4] = tbl[i].addr;
      settle();
      check("tbl_lat0", s_ar_valid, 0);
      cyc(); settle();
      check("tbl_lat1", {s_ar_valid, rd_owner}, {1'b1, tbl[i].id[0]});
      rd_xact(tbl[i].id, tbl[i].addr, tbl[i].data);
    end

    // Write, requester 1: W handshakes first, AW three cycles later.
    begin
      int aw0, w0;
      cyc();
      aw0 = aw_beats; w0 = w_beats;
      m_w_valid = 2'b10; m_w_data = {32'h5555AAAA, 32'h0}; m_aw_address = 8'hB0;
      cyc(); settle();
      check("wfirst_grant", {wr_busy, wr_owner, s_w_valid, s_aw_valid}, 4'b1110);
      check("wfirst_data", s_w_data, 32'h5555AAAA);
      s_w_ready = 1; settle();
      check("wfirst_wready", m_w_ready, 2'b10);
      for (int k = 1; k <= 3; k++) begin
        cyc();
        if (k == 3) begin m_aw_valid = 2'b10; s_aw_ready = 1; end
        settle();
        check("wfirst_no_rew", {m_w_ready, s_w_valid}, 0);
        check("wfirst_busy", wr_busy, 1);
      end
      check("wfirst_aw", {s_aw_valid, m_aw_ready, s_aw_address}, {1'b1, 2'b10, 4'hB});
      cyc();
      m_aw_valid = 0; m_w_valid = 0; s_aw_ready = 0; s_w_ready = 0; settle();
      check("wfirst_done", wr_busy, 0);
      check("wfirst_beats", {aw_beats - aw0, w_beats - w0}, {32'd1, 32'd1});
    end

    // Both requesters write; 0 wins and completes AW+W in one cycle.
    cyc();
    m_aw_valid = 2'b11; m_w_valid = 2'b11;
    m_aw_address = {4'h6, 4'h4}; m_w_data = {32'h66666666, 32'h44444444};
    cyc(); settle();
    check("wsame_owner", {wr_busy, wr_owner}, 2'b10);
    s_aw_ready = 1; s_w_ready = 1; settle();
    check("wsame_ready", {m_aw_ready, m_w_ready}, 4'b0101);
    check("wsame_fwd", {s_aw_address, s_w_data}, {4'h4, 32'h44444444});
    cyc();
    m_aw_valid = 2'b10; m_w_valid = 2'b10; s_aw_ready = 0; s_w_ready = 0; settle();
    check("wsame_release", {wr_busy, s_aw_valid}, 2'b00);
    cyc(); settle();
    check("wsame_next", {s_aw_valid, wr_owner, s_aw_address}, {1'b1, 1'b1, 4'h6});
    s_aw_ready = 1; s_w_ready = 1;
    cyc();
    m_aw_valid = 0; m_w_valid = 0; s_aw_ready = 0; s_w_ready = 0; settle();
    check("wsame_done", wr_busy, 0);

    // Read by 0 concurrent with write by 1.
    cyc();
    m_ar_valid = 2'b01; m_ar_address = 8'h0E;
    m_aw_valid = 2'b10; m_w_valid = 2'b10; m_aw_address = 8'h80; m_w_data = {32'h77777777, 32'h0};
    cyc(); settle();
    check("conc_owner", {rd_busy, rd_owner, wr_busy, wr_owner}, 4'b1011);
    s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1; settle();
    check("conc_route", {m_ar_ready, m_aw_ready, m_w_ready}, 6'b011010);
    cyc();
    m_ar_valid = 0; m_aw_valid = 0; m_w_valid = 0;
    s_ar_ready = 0; s_aw_ready = 0; s_w_ready = 0;
    s_r_valid = 1; s_r_data = 32'h0BADF00D; m_r_ready = 2'b11; settle();
    check("conc_state", {rd_busy, wr_busy}, 2'b10);
    check("conc_r", {m_r_valid, m_r_data}, {2'b01, 32'h0BADF00D});
    cyc();
    s_r_valid = 0; m_r_ready = 0; settle();

    // Reset in RD_DATA, requester 1 owning the read.
    m_ar_valid = 2'b10; m_ar_address = 8'hD0;
    cyc(); s_ar_ready = 1;
    cyc(); s_ar_ready = 0; m_ar_valid = 0; m_r_ready = 2'b10; settle();
    check("mid_pre", {rd_busy, rd_owner, s_r_ready}, 3'b111);
    #2 rst = 1; #1;
    check("mid_async", {rd_busy, rd_owner, s_r_ready, m_r_valid, m_ar_ready}, 0);
    m_r_ready = 0;
    cyc(); rst = 0;
    m_ar_valid = 2'b11; m_ar_address = {4'h8, 4'h1};
    cyc(); settle();
    check("post_rst_owner", {rd_busy, rd_owner}, 2'b10);
    rd_xact(0, 4'h1, 32'h13579BDF);
    rd_xact(1, 4'h8, 32'h2468ACE0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
endmodule
